// File: rtl/pipe_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, stallable pipelined unit among NREQ requesters.
// Optional occupancy counter (occ/busy ports) enabled by defining PIPE_UNIT_ARBITER_OCC_EN.
module pipe_unit_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 16,
    parameter int unsigned IDW   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [WIDTH-1:0]         op_data,
    output logic                     op_valid,
    output logic                     unit_stall,
    input  logic [WIDTH-1:0]         unit_result,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
`ifdef PIPE_UNIT_ARBITER_OCC_EN
    output logic [$clog2(LAT+1)-1:0] occ,
    output logic                     busy,
`endif
    input  logic [NREQ-1:0]          rsp_ready
);

    localparam int unsigned CW = IDW + 1;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [LAT-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0] tag_id_q [LAT];
    logic [IDW-1:0] tag_id_d [LAT];

    logic           tail_v;
    logic [IDW-1:0] tail_id;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [CW-1:0]  cand;
    logic           issue;
    logic           rsp_accept;

    assign tail_v     = tag_v_q[LAT-1];
    assign tail_id    = tag_id_q[LAT-1];
    assign unit_stall = tail_v & ~rsp_ready[tail_id];
    assign rsp_accept = tail_v & rsp_ready[tail_id];
    assign rsp_data   = unit_result;
    assign issue      = grant_found & ~unit_stall;

    always_comb begin
        rsp_valid          = '0;
        rsp_valid[tail_id] = tail_v;
    end

    // Search rr_ptr, rr_ptr+1, ... modulo NREQ; the extra bit keeps the wrap exact for any NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        op_valid  = 1'b0;
        op_data   = '0;
        rr_ptr_d  = rr_ptr_q;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            op_valid            = 1'b1;
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (grant_id == IDW'(k)) begin
                    op_data = req_data[k*WIDTH +: WIDTH];
                end
            end
            rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // Tags move in lockstep with the unit: bubbles shift too, everything holds on stall.
    always_comb begin
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        if (!unit_stall) begin
            tag_v_d[0]  = op_valid;
            tag_id_d[0] = grant_id;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_v_d[i]  = tag_v_q[i-1];
                tag_id_d[i] = tag_id_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            tag_v_q  <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
        end
    end

`ifdef PIPE_UNIT_ARBITER_OCC_EN
    localparam int unsigned OW = $clog2(LAT + 1);

    logic [OW-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (issue && !rsp_accept) begin
            occ_d = occ_q + OW'(1);
        end else if (!issue && rsp_accept) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign busy = (occ_q != '0);
`endif

endmodule

// File: tb/tb_pipe_unit_arbiter.sv
// Self-checking bench for pipe_unit_arbiter: FIFO-of-tokens reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_pipe_unit_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 16;
    localparam int IDW  = 2;
    localparam int OW   = $clog2(LAT + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0] req_ready;
    logic [W-1:0]    op_data;
    logic            op_valid;
    logic            unit_stall;
    logic [W-1:0]    unit_result;
    logic [NREQ-1:0] rsp_valid;
    logic [W-1:0]    rsp_data;
    logic [NREQ-1:0] rsp_ready = '1;
`ifdef PIPE_UNIT_ARBITER_OCC_EN
    logic [OW-1:0]   occ;
    logic            busy;
`endif

    // Second, small instance for the non-power-of-2 wrap case.
    logic [2:0]  b_req_valid = '0;
    logic [23:0] b_req_data  = '0;
    logic [2:0]  b_req_ready;
    logic [7:0]  b_op_data;
    logic        b_op_valid;
    logic        b_unit_stall;
    logic [2:0]  b_rsp_valid;
    logic [7:0]  b_rsp_data;
`ifdef PIPE_UNIT_ARBITER_OCC_EN
    logic [1:0]  b_occ;
    logic        b_busy;
`endif

    always #5 clk = ~clk;

    pipe_unit_arbiter #(.NREQ(NREQ), .WIDTH(W), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .op_data(op_data), .op_valid(op_valid), .unit_stall(unit_stall),
        .unit_result(unit_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`ifdef PIPE_UNIT_ARBITER_OCC_EN
        .occ(occ), .busy(busy),
`endif
        .rsp_ready(rsp_ready)
    );

    pipe_unit_arbiter #(.NREQ(3), .WIDTH(8), .LAT(2), .IDW(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .op_data(b_op_data), .op_valid(b_op_valid),
        .unit_stall(b_unit_stall), .unit_result(8'h00), .rsp_valid(b_rsp_valid),
        .rsp_data(b_rsp_data),
`ifdef PIPE_UNIT_ARBITER_OCC_EN
        .occ(b_occ), .busy(b_busy),
`endif
        .rsp_ready(3'b111)
    );

    // Identity unit: LAT-deep delay line, common stall, shared reset.
    logic [W-1:0] unit_line [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) unit_line[i] <= '0;
        end else if (!unit_stall) begin
            unit_line[0] <= op_data;
            for (int i = 1; i < LAT; i++) unit_line[i] <= unit_line[i-1];
        end
    end
    assign unit_result = unit_line[LAT-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_id(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: in-flight tokens in issue order, each stamped with the count of
    // non-stalled cycles at its issue; it is at the tail once LAT-1 further advances happen.
    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           t;
    } tok_t;

    tok_t         m_q[$];
    int           m_rr  = 0;
    int           m_adv = 0;
    logic         s_issue = 1'b0, s_stall = 1'b0, s_accept = 1'b0;
    int           s_g = 0;
    logic [W-1:0] s_data = '0;

    logic            e_tv, e_stall, e_issue;
    int              e_tid, e_g;
    logic [NREQ-1:0] e_rv, e_rr;
    logic [W-1:0]    e_od;

    always @(negedge clk) begin
        if (!rst) begin
            e_tv  = (m_q.size() > 0) && (m_adv - m_q[0].t == LAT - 1);
            e_tid = e_tv ? m_q[0].id : 0;
            e_stall = e_tv && !rsp_ready[e_tid];
            e_rv = '0;
            if (e_tv) e_rv[e_tid] = 1'b1;
            e_g = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (e_g < 0 && req_valid[(m_rr + i) % NREQ]) e_g = (m_rr + i) % NREQ;
            end
            e_issue = (e_g >= 0) && !e_stall;
            e_rr = '0;
            e_od = '0;
            if (e_issue) begin
                e_rr[e_g] = 1'b1;
                e_od = req_data[e_g*W +: W];
            end
            chk("sb_unit_stall", unit_stall, e_stall);
            chk("sb_rsp_valid", rsp_valid, e_rv);
            if (e_tv) chk("sb_rsp_data", rsp_data, m_q[0].data);
            chk("sb_req_ready", req_ready, e_rr);
            chk("sb_op_valid", op_valid, e_issue);
            chk("sb_op_data", op_data, e_od);
`ifdef PIPE_UNIT_ARBITER_OCC_EN
            chk("sb_occ", occ, m_q.size());
            chk("sb_busy", busy, m_q.size() != 0);
`endif
            s_issue  = e_issue;
            s_stall  = e_stall;
            s_accept = e_tv && !e_stall;
            s_g      = e_g;
            s_data   = e_od;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_rr = 0;
            m_adv = 0;
            s_issue = 1'b0;
            s_stall = 1'b0;
            s_accept = 1'b0;
        end else begin
            if (s_accept) void'(m_q.pop_front());
            if (!s_stall) begin
                tok_t tk;
                m_adv++;
                if (s_issue) begin
                    tk.id = s_g;
                    tk.data = s_data;
                    tk.t = m_adv;
                    m_q.push_back(tk);
                    m_rr = (s_g + 1) % NREQ;
                end
            end
        end
    end

    int stim_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        stim_cyc++;
    endtask

    task automatic set_data();
        for (int k = 0; k < NREQ; k++) req_data[k*W +: W] = {8'(k), 24'(stim_cyc)};
    endtask

    task automatic run(input int n);
        repeat (n) begin
            set_data();
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        b_req_valid = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    int gr[$];
    int rs[$];
    int first_rsp;
    int exp8[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit found;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and single request round trip.
        do_reset(2);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_unit_stall", unit_stall, 1'b0);
        chk("rst_op_valid", op_valid, 1'b0);
        tick();
        req_valid = 4'b0100;
        req_data[2*W +: W] = 32'hA5;
        @(negedge clk);
        chk("t1_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            chk("t1_rsp_valid", rsp_valid, (i == LAT) ? 4'b0100 : 4'b0000);
            if (i == LAT) chk("t1_rsp_data", rsp_data, 32'hA5);
`ifdef PIPE_UNIT_ARBITER_OCC_EN
            if (i == 1) chk("t1_occ_one", occ, 1);
`endif
        end
        tick();
`ifdef PIPE_UNIT_ARBITER_OCC_EN
        @(negedge clk);
        chk("t1_occ_zero", occ, 0);
`endif

        // All requesters valid continuously from reset.
        do_reset(2);
        req_valid = '1;
        first_rsp = -1;
        for (int c = 0; c < 30; c++) begin
            set_data();
            @(negedge clk);
            if (oh_id(req_ready) >= 0) gr.push_back(oh_id(req_ready));
            if (oh_id(rsp_valid) >= 0) begin
                if (first_rsp < 0) first_rsp = c;
                rs.push_back(oh_id(rsp_valid));
            end
            tick();
        end
        chk("t2_grant_count", gr.size(), 30);
        chk("t2_rsp_count", rs.size(), 14);
        chk("t2_first_rsp", first_rsp, LAT);
        for (int i = 0; i < 8; i++) begin
            chk("t2_grant_order", gr[i], exp8[i]);
            chk("t2_rsp_order", rs[i], exp8[i]);
        end

        // Requester 1 holds off its response for five cycles while it sits at the tail.
        rsp_ready = 4'b1101;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            set_data();
            @(negedge clk);
            if (rsp_valid[1]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t3_found_tail", found, 1'b1);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin
                tick();
                @(negedge clk);
            end
            chk("t3_stall", unit_stall, 1'b1);
            chk("t3_req_ready", req_ready, 4'b0000);
        end
        tick();
        rsp_ready = '1;
        @(negedge clk);
        chk("t3_release_stall", unit_stall, 1'b0);
        chk("t3_release_rsp", rsp_valid, 4'b0010);
        chk("t3_release_issue", req_ready != 0, 1'b1);
        run(20);
        req_valid = '0;
        run(LAT + 4);

        // Stalled tail with a new request that must wait, then issue alongside the response.
        do_reset(2);
        rsp_ready = 4'b1110;
        req_valid = 4'b0001;
        req_data[0 +: W] = 32'h11;
        tick();
        req_valid = '0;
        found = 1'b0;
        for (int n = 0; n < LAT + 4; n++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t4_found_tail", found, 1'b1);
        tick();
        req_valid = 4'b1000;
        req_data[3*W +: W] = 32'h33;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("t4_blocked", req_ready, 4'b0000);
            chk("t4_stall", unit_stall, 1'b1);
            tick();
        end
        rsp_ready = '1;
        @(negedge clk);
        chk("t4_issue", req_ready, 4'b1000);
        chk("t4_rsp", rsp_valid, 4'b0001);
        chk("t4_rsp_data", rsp_data, 32'h11);
        tick();
        req_valid = '0;
`ifdef PIPE_UNIT_ARBITER_OCC_EN
        @(negedge clk);
        chk("t4_occ_same", occ, 1);
`endif
        run(LAT + 4);

        // NREQ=3 wrap from rr_ptr=2 back to 0.
        do_reset(2);
        b_req_valid = 3'b001;
        @(negedge clk);
        chk("t5_grant0", b_req_ready, 3'b001);
        tick();
        b_req_valid = 3'b010;
        @(negedge clk);
        chk("t5_grant1", b_req_ready, 3'b010);
        tick();
        b_req_valid = 3'b101;
        @(negedge clk);
        chk("t5_grant2", b_req_ready, 3'b100);
        tick();
        @(negedge clk);
        chk("t5_wrap0", b_req_ready, 3'b001);
        tick();
        b_req_valid = '0;

        // Reset with ten tokens in flight discards them all.
        do_reset(2);
        req_valid = '1;
        run(10);
        req_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", rsp_valid, 4'b0000);
            if (i == 0) begin
                chk("t6_stall", unit_stall, 1'b0);
                chk("t6_op_valid", op_valid, 1'b0);
`ifdef PIPE_UNIT_ARBITER_OCC_EN
                chk("t6_occ", occ, 0);
`endif
            end
            tick();
        end
        req_valid = '1;
        req_data[0 +: W] = 32'h5A;
        @(negedge clk);
        chk("t6_rr_zero", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            chk("t6_rsp_valid", rsp_valid, (i == LAT) ? 4'b0001 : 4'b0000);
            if (i == LAT) chk("t6_rsp_data", rsp_data, 32'h5A);
        end
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
